// File: rtl/eis_mul_seq.sv
// rtl/eis_mul_seq.sv - EIS MUL sequencer: drives the iterative multiplier, writes back the product, sets condition codes.
module eis_mul_seq #(
  parameter int TIMEOUT = 32,
  parameter int TW      = 6
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  rs,
  input  logic [15:0] src,
  input  logic [15:0] dst,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        mul_ready,
  output logic [15:0] mul_a,
  output logic [15:0] mul_b,
  input  logic        mul_done,
  input  logic [31:0] mul_product,
  output logic        rf_we,
  output logic [2:0]  rf_waddr,
  output logic [15:0] rf_wdata,
  output logic        cc_we,
  output logic        cc_n,
  output logic        cc_z,
  output logic        cc_v,
  output logic        cc_c
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_WRH  = 3'd2,
    S_WRL  = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [15:0]   a_q, b_q;
  logic [2:0]    rs_q;
  logic [31:0]   prod_q;
  logic [TW-1:0] cnt_q;
  logic          prod_ovf;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operands, destination and product are captured only at the state transitions that own them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q    <= '0;
      b_q    <= '0;
      rs_q   <= '0;
      prod_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (state_q == S_IDLE && start) begin
        a_q   <= src;
        b_q   <= dst;
        rs_q  <= rs;
        cnt_q <= '0;
      end
      if (state_q == S_RUN) begin
        if (mul_done) begin
          prod_q <= mul_product;
        end else begin
          cnt_q <= cnt_q + TW'(1);
        end
      end
    end
  end

  // Product fits a signed 16-bit word only when bits 31..15 are all equal.
  assign prod_ovf = !((&prod_q[31:15]) || !(|prod_q[31:15]));

  assign mul_a = a_q;
  assign mul_b = b_q;

  always_comb begin
    state_d   = state_q;
    busy      = 1'b1;
    done      = 1'b0;
    err       = 1'b0;
    mul_ready = 1'b0;
    rf_we     = 1'b0;
    rf_waddr  = 3'd0;
    rf_wdata  = 16'd0;
    cc_we     = 1'b0;
    cc_n      = 1'b0;
    cc_z      = 1'b0;
    cc_v      = 1'b0;
    cc_c      = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        mul_ready = 1'b1;
        if (mul_done) begin
          state_d = rs_q[0] ? S_WRL : S_WRH;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ERR;
        end
      end
      S_WRH: begin
        rf_we    = 1'b1;
        rf_waddr = rs_q;
        rf_wdata = prod_q[31:16];
        state_d  = S_WRL;
      end
      S_WRL: begin
        rf_we    = 1'b1;
        rf_waddr = rs_q | 3'b001;
        rf_wdata = prod_q[15:0];
        cc_we    = 1'b1;
        done     = 1'b1;
        cc_n     = prod_q[31];
        cc_z     = (prod_q == 32'd0);
        cc_c     = prod_ovf;
        state_d  = S_IDLE;
      end
      S_ERR: begin
        err     = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
